// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
//   Shared-ALU scheduler. Up to NREQ requesters compete for one
//   add/subtract/compare datapath. Only one operation is in flight at a time.
//   Each operation takes three cycles: accept (IDLE), execute (EXEC) and
//   respond (RESP).
//
//   Handshake rule (request and response sides): a transfer happens on a
//   rising clk edge where valid and ready are both high. A producer holds
//   valid and payload stable until that edge. A requester may drop
//   req_valid before it is granted; this withdraws the request.
//
//   Build option: define ALU_SCHED_RR_EN for round-robin arbitration.
//   If it is not defined, the arbiter uses fixed priority (lowest index
//   wins) and no pointer is built.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[NREQ]   per-requester request valid
//   req_ready[NREQ]   one-hot grant / accept strobe (IDLE only)
//   req_op[2*NREQ]    opcode: 00 ADD, 01 ADC, 10 SUB, 11 CMP
//   req_cin[NREQ]     carry-in, used by ADC only
//   req_a/req_b       operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid         result valid (RESP state)
//   rsp_ready         consumer accepts result
//   rsp_id            index of the requester that owns the result
//   rsp_y             sum/difference, 0 for CMP
//   rsp_flags         {cout, eq, lt, gt}, unsigned a vs b
//   dbg_state         FSM state: 0 IDLE, 1 EXEC, 2 RESP
// -----------------------------------------------------------------------------
module alu_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [NREQ-1:0]         req_cin,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_y,
  output logic [3:0]              rsp_flags,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_id;
  logic             accept;
  int               idx;

`ifdef ALU_SCHED_RR_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  // Arbiter. The search order starts at the round-robin pointer, or at
  // index 0 when the arbiter is fixed priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_SCHED_RR_EN
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
`else
      idx = k;
`endif
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign accept = (state_q == S_IDLE) && gnt_found && rst_n;

  // ALU result, computed from the operands that were latched at accept.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;

  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q} +
               {{WIDTH{1'b0}}, (op_q == OP_ADC) & cin_q};
    alu_y    = '0;
    alu_cout = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        alu_y    = sum_ext[WIDTH-1:0];
        alu_cout = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_y    = a_q - b_q;
        alu_cout = (a_q >= b_q);     // no-borrow convention
      end
      default: begin                 // CMP: flags only
        alu_y    = '0;
        alu_cout = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_EXEC;
      S_EXEC:                 state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Datapath and pointer next values
  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
`ifdef ALU_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif
    if (accept) begin
      op_d  = req_op[int'(gnt_id)*2 +: 2];
      a_d   = req_a[int'(gnt_id)*WIDTH +: WIDTH];
      b_d   = req_b[int'(gnt_id)*WIDTH +: WIDTH];
      cin_d = req_cin[gnt_id];
      id_d  = gnt_id;
`ifdef ALU_SCHED_RR_EN
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
    end
    if (state_q == S_EXEC) begin
      rsp_id_d    = id_q;
      rsp_y_d     = alu_y;
      rsp_flags_d = {alu_cout, a_q == b_q, a_q < b_q, a_q > b_q};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
`ifdef ALU_SCHED_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
`ifdef ALU_SCHED_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
    rsp_valid = (state_q == S_RESP);
    rsp_id    = rsp_id_q;
    rsp_y     = rsp_y_q;
    rsp_flags = rsp_flags_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [NREQ-1:0]       req_cin;
  logic [WIDTH*NREQ-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_y;
  logic [3:0]            rsp_flags;
  logic [1:0]            dbg_state;

  int n_vec = 0;
  int n_err = 0;

  alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_req(input int i, input logic [1:0] op, input logic cin,
                           input logic [7:0] a, input logic [7:0] b);
    req_op[i*2 +: 2]         = op;
    req_cin[i]               = cin;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
    req_valid[i]             = 1'b1;
  endtask

  // Full single-requester transaction. It is called at posedge+1, and it
  // checks the grant, the EXEC cycle, the response and the return to IDLE.
  task automatic do_op(input int i, input logic [1:0] op, input logic cin,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ey, input logic [3:0] ef,
                       input string name);
    int t;
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[i] = 1'b1;
    drive_req(i, op, cin, a, b);
    rsp_ready = 1'b1;
    #1;
    t = 0;
    while (!req_ready[i] && t < 20) begin @(posedge clk); #1; t++; end
    n_vec++;
    if (req_ready !== exp_rdy) begin
      $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, exp_rdy);
      n_err++;
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd1) begin
      $display("FAIL %s exec: rsp_valid=%b state=%0d expected 0/1", name, rsp_valid, dbg_state);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== IDW'(i) || rsp_y !== ey || rsp_flags !== ef) begin
      $display("FAIL %s rsp: valid=%b id=%0d y=%0d flags=%b expected 1 id=%0d y=%0d flags=%b",
               name, rsp_valid, rsp_id, rsp_y, rsp_flags, i, ey, ef);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL %s done: rsp_valid=%b state=%0d expected 0/0", name, rsp_valid, dbg_state);
      n_err++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req_valid = '0; req_op = '0; req_cin = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    req_valid = '1;
    #10;
    n_vec++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_y !== 8'd0 ||
        rsp_flags !== 4'd0 || rsp_id !== 2'd0 || dbg_state !== 2'd0) begin
      $display("FAIL reset: rdy=%b v=%b y=%0d f=%b id=%0d st=%0d expected all 0",
               req_ready, rsp_valid, rsp_y, rsp_flags, rsp_id, dbg_state);
      n_err++;
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
      n_err++;
    end
    req_valid = '0;   // withdraw before the edge; nothing is accepted
    @(posedge clk); #1;
    n_vec++;
    if (dbg_state !== 2'd0 || req_ready !== 4'b0000) begin
      $display("FAIL withdraw: state=%0d rdy=%b expected 0/0000", dbg_state, req_ready);
      n_err++;
    end
  endtask

  task automatic test_arbitration;
    int t;
    logic [IDW-1:0] exp_id[5];
`ifdef ALU_SCHED_RR_EN
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < NREQ; i++) drive_req(i, 2'b00, 1'b0, 8'(i), 8'd10);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      #0;
      while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k] ||
          rsp_y !== 8'(exp_id[k]) + 8'd10) begin
        $display("FAIL arb[%0d]: valid=%b id=%0d y=%0d expected 1 id=%0d y=%0d",
                 k, rsp_valid, rsp_id, rsp_y, exp_id[k], 8'(exp_id[k]) + 8'd10);
        n_err++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_ops;
    do_op(2, 2'b00, 1'b0, 8'd200, 8'd100, 8'd44,  4'b1001, "add_wrap");
    do_op(1, 2'b10, 1'b0, 8'd5,   8'd7,   8'd254, 4'b0010, "sub_borrow");
    do_op(3, 2'b11, 1'b0, 8'd9,   8'd9,   8'd0,   4'b0100, "cmp_eq");
    do_op(0, 2'b01, 1'b1, 8'd255, 8'd0,   8'd0,   4'b1001, "adc_carry");
    do_op(2, 2'b00, 1'b0, 8'd255, 8'd1,   8'd0,   4'b1001, "add_2pw");
    do_op(1, 2'b10, 1'b0, 8'd7,   8'd5,   8'd2,   4'b1001, "sub_pos");
    do_op(0, 2'b10, 1'b0, 8'd9,   8'd9,   8'd0,   4'b1100, "sub_zero");
    do_op(3, 2'b00, 1'b1, 8'd3,   8'd4,   8'd7,   4'b0010, "add_cin_ign");
    do_op(2, 2'b11, 1'b1, 8'd3,   8'd200, 8'd0,   4'b0010, "cmp_lt");
  endtask

  task automatic test_backpressure;
    int t;
    drive_req(0, 2'b00, 1'b0, 8'd10, 8'd20);
    rsp_ready = 1'b0;
    #1;
    t = 0;
    while (!req_ready[0] && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drive_req(1, 2'b00, 1'b0, 8'd1, 8'd2);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'd30 || rsp_id !== 2'd0 ||
          rsp_flags !== 4'b0010 || req_ready !== 4'b0000) begin
        $display("FAIL hold[%0d]: v=%b y=%0d id=%0d f=%b rdy=%b expected 1 30 0 0010 0000",
                 c, rsp_valid, rsp_y, rsp_id, rsp_flags, req_ready);
        n_err++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (dbg_state !== 2'd0 || req_ready !== 4'b0010) begin
      $display("FAIL release: state=%0d rdy=%b expected 0/0010", dbg_state, req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'd3 || rsp_flags !== 4'b0010) begin
      $display("FAIL next_op: v=%b id=%0d y=%0d f=%b expected 1 1 3 0010",
               rsp_valid, rsp_id, rsp_y, rsp_flags);
      n_err++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int t;
    drive_req(1, 2'b00, 1'b0, 8'd1, 8'd1);
    rsp_ready = 1'b1;
    #1;
    t = 0;
    while (!req_ready[1] && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    n_vec++;
    if (dbg_state !== 2'd1) begin
      $display("FAIL midop_exec: state=%0d expected 1", dbg_state);
      n_err++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || dbg_state !== 2'd0) begin
      $display("FAIL midop_rst: v=%b rdy=%b st=%0d expected 0 0000 0", rsp_valid, req_ready, dbg_state);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL midop_norsp: rsp_valid=%b expected 0", rsp_valid);
      n_err++;
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL midop_regrant: rdy=%b expected 0010", req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'd2 || rsp_flags !== 4'b0100) begin
      $display("FAIL midop_rsp: v=%b id=%0d y=%0d f=%b expected 1 1 2 0100",
               rsp_valid, rsp_id, rsp_y, rsp_flags);
      n_err++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_ops();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound so the run always ends on its own.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
